// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus between the two writeback requesters and the register file
// arbiter. The master side drives requests and hold; the slave side (the
// arbiter) returns readys plus the registered write/forwarding command.
interface regfile_write_arbiter_if;
    logic        hold;

    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;

    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;

    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;

    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;

    modport master (
        output hold,
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  RegWrite, WriteAddr, WriteData,
        input  fwd_valid, fwd_addr, fwd_data
    );

    modport slave (
        input  hold,
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output RegWrite, WriteAddr, WriteData,
        output fwd_valid, fwd_addr, fwd_data
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: fixed priority to the main pipeline
// writeback (req0), with a saturating starvation counter that forces the
// multi-cycle unit (req1) through after STARVE_MAX consecutive losses.
// The winning command is registered and doubles as the forwarding source.
module regfile_write_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input logic                    clock,
    input logic                    reset,
    regfile_write_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    logic [3:0] starveCnt;
    logic       active;
    logic       contend0, contend1;
    logic       drop0, drop1;
    logic       grant0, grant1;

    // Classify each request (contender vs address-0 drop) and pick the winner.
    always_comb begin
        active   = reset && !bus.hold;
        contend0 = active && bus.req0_valid && (bus.req0_addr != 5'd0);
        contend1 = active && bus.req1_valid && (bus.req1_addr != 5'd0);
        drop0    = active && bus.req0_valid && (bus.req0_addr == 5'd0);
        drop1    = active && bus.req1_valid && (bus.req1_addr == 5'd0);
        grant1   = contend1 && (!contend0 || (starveCnt == STARVE_LIMIT));
        grant0   = contend0 && !grant1;
        bus.req0_ready = grant0 || drop0;
        bus.req1_ready = grant1 || drop1;
    end

    // Starvation counter: counts consecutive lost arbitrations of req1, frozen by hold.
    always_ff @(posedge clock) begin
        if (!reset) begin
            starveCnt <= 4'd0;
        end else if (!bus.hold) begin
            if (grant1 || !contend1)
                starveCnt <= 4'd0;
            else if (starveCnt < STARVE_LIMIT)
                starveCnt <= starveCnt + 4'd1;
        end
    end

    // Registered write command; address/data hold their value on idle cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.RegWrite  <= 1'b0;
            bus.WriteAddr <= 5'd0;
            bus.WriteData <= 32'd0;
        end else if (grant0) begin
            bus.RegWrite  <= 1'b1;
            bus.WriteAddr <= bus.req0_addr;
            bus.WriteData <= bus.req0_data;
        end else if (grant1) begin
            bus.RegWrite  <= 1'b1;
            bus.WriteAddr <= bus.req1_addr;
            bus.WriteData <= bus.req1_data;
        end else begin
            bus.RegWrite  <= 1'b0;
        end
    end

    // The in-flight write is visible for bypass during the cycle before commit.
    assign bus.fwd_valid = bus.RegWrite;
    assign bus.fwd_addr  = bus.WriteAddr;
    assign bus.fwd_data  = bus.WriteData;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by random
// traffic, all checked each cycle against a behavioural arbitration model.
module tb_regfile_write_arbiter;
    localparam int STARVE_MAX = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    regfile_write_arbiter_if bus();

    regfile_write_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Behavioural model state
    logic        mWe;
    logic [4:0]  mAddr;
    logic [31:0] mData;
    int          mLost;

    // Register file as built from the DUT's write command
    logic [31:0] dutRf [32];

    // Observed transfers of the last step
    bit xfer0, xfer1;

    always @(posedge clock) begin
        if (reset && bus.RegWrite)
            dutRf[bus.WriteAddr] <= bus.WriteData;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs at negedge against the model, advance the model,
    // then step past the rising edge so new inputs can be driven.
    task automatic step();
        bit c0, c1, z0, z1, w0, w1, on;
        @(negedge clock);
        on = reset && !bus.hold;
        c0 = on && bus.req0_valid && bus.req0_addr != 0;
        c1 = on && bus.req1_valid && bus.req1_addr != 0;
        z0 = on && bus.req0_valid && bus.req0_addr == 0;
        z1 = on && bus.req1_valid && bus.req1_addr == 0;
        w1 = (c0 && c1) ? (mLost >= STARVE_MAX) : c1;
        w0 = c0 && !w1;

        checkVal("req0_ready", 32'(bus.req0_ready), 32'(w0 || z0));
        checkVal("req1_ready", 32'(bus.req1_ready), 32'(w1 || z1));
        checkVal("RegWrite",   32'(bus.RegWrite),   32'(mWe));
        checkVal("WriteAddr",  32'(bus.WriteAddr),  32'(mAddr));
        checkVal("WriteData",  bus.WriteData,       mData);
        checkVal("fwd_valid",  32'(bus.fwd_valid),  32'(mWe));
        checkVal("fwd_addr",   32'(bus.fwd_addr),   32'(mAddr));
        checkVal("fwd_data",   bus.fwd_data,        mData);
        checkVal("starve_cnt", 32'(dut.starveCnt),  32'(mLost));

        xfer0 = bus.req0_valid && bus.req0_ready;
        xfer1 = bus.req1_valid && bus.req1_ready;

        if (!reset) begin
            mWe = 1'b0; mAddr = '0; mData = '0; mLost = 0;
        end else begin
            mWe = w0 || w1;
            if (w0) begin mAddr = bus.req0_addr; mData = bus.req0_data; end
            if (w1) begin mAddr = bus.req1_addr; mData = bus.req1_data; end
            if (!bus.hold)
                mLost = (c1 && !w1) ? ((mLost + 1 > STARVE_MAX) ? STARVE_MAX : mLost + 1) : 0;
        end
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] randAddr();
        return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endfunction

    initial begin
        int grantIdx;
        int n;
        mWe = 0; mAddr = 0; mData = 0; mLost = 0;
        for (int i = 0; i < 32; i++) dutRf[i] = 32'd0;
        bus.hold = 0;
        bus.req0_valid = 0; bus.req0_addr = 0; bus.req0_data = 0;
        bus.req1_valid = 0; bus.req1_addr = 0; bus.req1_data = 0;

        // Reset state
        @(posedge clock); #1;
        step(); step();
        reset = 1;
        step();

        // Single request
        bus.req0_valid = 1; bus.req0_addr = 5; bus.req0_data = 32'hDEADBEEF;
        step();
        bus.req0_valid = 0;
        step(); step();

        // Priority and starvation
        n = 0;
        grantIdx = -1;
        bus.req0_valid = 1; bus.req0_addr = 1; bus.req0_data = 32'h100;
        bus.req1_valid = 1; bus.req1_addr = 9; bus.req1_data = 32'h99;
        for (int i = 0; i < 9; i++) begin
            step();
            if (xfer1 && grantIdx < 0) grantIdx = i;
            if (xfer1) bus.req1_valid = 0;
            if (xfer0) begin
                n++;
                bus.req0_addr = 5'((n % 8) + 1);
                bus.req0_data = 32'h100 + 32'(n);
            end
        end
        checkVal("starve_grant_idx", 32'(grantIdx), 32'(STARVE_MAX));
        bus.req0_valid = 0;
        step();

        // Address 0 drop alongside a real write
        bus.req0_valid = 1; bus.req0_addr = 0; bus.req0_data = 32'hAAAA;
        bus.req1_valid = 1; bus.req1_addr = 3; bus.req1_data = 32'h33;
        step();
        bus.req0_valid = 0; bus.req1_valid = 0;
        step(); step();
        checkVal("rf3", dutRf[3], 32'h33);

        // Hold with a partly charged counter
        bus.req0_valid = 1; bus.req0_addr = 10; bus.req0_data = 32'hA0;
        bus.req1_valid = 1; bus.req1_addr = 11; bus.req1_data = 32'hB0;
        step(); step();
        bus.hold = 1;
        step(); step(); step();
        bus.hold = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (xfer1) bus.req1_valid = 0;
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        step();

        // Reset right after a req1 grant
        bus.req1_valid = 1; bus.req1_addr = 20; bus.req1_data = 32'h44;
        step();
        bus.req1_data = 32'h45;
        reset = 0;
        step(); step();
        bus.req1_valid = 0;
        reset = 1;
        step(); step();
        checkVal("rst_discard", dutRf[20], 32'h0);

        // Same-address collision
        bus.req0_valid = 1; bus.req0_addr = 7; bus.req0_data = 32'h11;
        bus.req1_valid = 1; bus.req1_addr = 7; bus.req1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            step();
            if (xfer0) bus.req0_valid = 0;
            if (xfer1) bus.req1_valid = 0;
        end
        checkVal("rf7_final", dutRf[7], 32'h22);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!bus.req0_valid || xfer0) begin
                bus.req0_valid = ($urandom_range(0, 3) != 0);
                bus.req0_addr  = randAddr();
                bus.req0_data  = $urandom;
            end
            if (!bus.req1_valid || xfer1) begin
                bus.req1_valid = ($urandom_range(0, 2) != 0);
                bus.req1_addr  = randAddr();
                bus.req1_data  = $urandom;
            end
            bus.hold = ($urandom_range(0, 9) == 0);
            reset    = ($urandom_range(0, 79) != 0);
        end
        reset = 1; bus.hold = 0; bus.req0_valid = 0; bus.req1_valid = 0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
